// File: rtl/bin_to_decimal_convertor.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN_TO_DECIMAL_SEG_EN to add a registered 7-segment output (Seg_out).
module bin_to_decimal_convertor #(
    parameter int BIN_WIDTH  = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    Start,
    input  logic [BIN_WIDTH-1:0]    Binary_in,
    output logic [4*BCD_DIGITS-1:0] Decimal_out,
`ifdef BIN_TO_DECIMAL_SEG_EN
    output logic [7*BCD_DIGITS-1:0] Seg_out,
`endif
    output logic                    Busy,
    output logic                    Done
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int TOT_W = BCD_W + BIN_WIDTH;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     decimal_q, decimal_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [BCD_W-1:0]     bcd_adj;
    logic [TOT_W-1:0]     shifted;

`ifdef BIN_TO_DECIMAL_SEG_EN
    logic [7*BCD_DIGITS-1:0] seg_q, seg_d;

    // Active-high {g,f,e,d,c,b,a}; non-decimal codes never occur, so they blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction
`endif

    // Add-3 correction before the shift keeps every digit in 0..9 after doubling.
    always_comb begin
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
        shifted = {bcd_adj[BCD_W-2:0], shift_q, 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        decimal_d = decimal_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef BIN_TO_DECIMAL_SEG_EN
        seg_d     = seg_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start) begin
                    shift_d = Binary_in;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(BIN_WIDTH);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d   = shifted[TOT_W-1:BIN_WIDTH];
                shift_d = shifted[BIN_WIDTH-1:0];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    decimal_d = shifted[TOT_W-1:BIN_WIDTH];
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
`ifdef BIN_TO_DECIMAL_SEG_EN
                    for (int k = 0; k < BCD_DIGITS; k++)
                        seg_d[7*k +: 7] = seg_digit(shifted[BIN_WIDTH + 4*k +: 4]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            decimal_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BIN_TO_DECIMAL_SEG_EN
            seg_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            decimal_q <= decimal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef BIN_TO_DECIMAL_SEG_EN
            seg_q     <= seg_d;
`endif
        end
    end

    assign Decimal_out = decimal_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
`ifdef BIN_TO_DECIMAL_SEG_EN
    assign Seg_out     = seg_q;
`endif

endmodule
